mc_fifo: RTL and testbench

//  Multi-channel synchronous FIFO; next generation of the single-channel fifo.
//  NUM_CH independent queues share one storage RAM, one write port and one read port.

---
 rtl/mc_fifo_pkg.sv | 32 +++
 rtl/mc_fifo_ram.sv | 48 ++++
 rtl/mc_fifo.sv | 133 +++++++++++++
 tb/tb_mc_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_fifo_pkg.sv
// rtl/mc_fifo_pkg.sv - mc_fifo default parameters, flag bundle and level/threshold helpers
package mc_fifo_pkg;

  localparam int DEF_DATA_WIDTH  = 128;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_ALMOST_MTY  = 3;
  localparam int DEF_ALMOST_FULL = 3;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_mty;
  } ch_flags_t;

  // Pointers carry one wrap bit, so the modular difference is the fill count.
  function automatic int lvl_calc(input int wr_ptr, input int rd_ptr, input int lvl_w);
    return (wr_ptr - rd_ptr) & ((1 << lvl_w) - 1);
  endfunction

  function automatic ch_flags_t flag_calc(input int lvl, input int depth,
                                          input int almost_mty, input int almost_full);
    ch_flags_t f;
    f.full        = (lvl == depth);
    f.empty       = (lvl == 0);
    f.almost_full = (lvl >= depth - almost_full);
    f.almost_mty  = (lvl <= almost_mty);
    return f;
  endfunction

endpackage

// File: rtl/mc_fifo_ram.sv
// rtl/mc_fifo_ram.sv - shared 1W/1R storage for all channels
// Registered read port by default; ASYNC_RD selects the combinational port for fall-through.
module mc_fifo_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_W     = 6,
  parameter bit ASYNC_RD   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int ENTRIES = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [ENTRIES];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Storage is deliberately not reset; only the output register is.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem_q[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = ASYNC_RD ? mem_q[rd_addr] : rd_data_q;

endmodule

// File: rtl/mc_fifo.sv
// rtl/mc_fifo.sv - multi-channel synchronous FIFO over one shared RAM
// Define MC_FIFO_FWFT_EN for first-word fall-through reads; default is a registered 1-cycle read.
module mc_fifo
  import mc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int ALMOST_MTY  = DEF_ALMOST_MTY,
  parameter int ALMOST_FULL = DEF_ALMOST_FULL,
  localparam int CH_W       = $clog2(NUM_CH),
  localparam int LVL_W      = $clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    rd_en,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    rd_vld,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH-1:0]       almost_mty,
  output logic [NUM_CH*LVL_W-1:0] level,
  input  logic                    err_clr,
  output logic [NUM_CH-1:0]       err_ovf,
  output logic [NUM_CH-1:0]       err_udf
);

  localparam int ADDR_W = CH_W + LVL_W - 1;

`ifdef MC_FIFO_FWFT_EN
  localparam bit FWFT = 1'b1;
`else
  localparam bit FWFT = 1'b0;
`endif

  logic [LVL_W-1:0]  wr_ptr_q [NUM_CH];
  logic [LVL_W-1:0]  wr_ptr_d [NUM_CH];
  logic [LVL_W-1:0]  rd_ptr_q [NUM_CH];
  logic [LVL_W-1:0]  rd_ptr_d [NUM_CH];
  logic [NUM_CH-1:0] err_ovf_q, err_ovf_d;
  logic [NUM_CH-1:0] err_udf_q, err_udf_d;
  logic              rd_vld_q, rd_vld_d;

  logic              wr_acc, rd_acc;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [LVL_W-1:0] lvl;
    ch_flags_t        flg;

    assign lvl = LVL_W'(lvl_calc(int'(wr_ptr_q[c]), int'(rd_ptr_q[c]), LVL_W));
    assign flg = flag_calc(int'(lvl), DEPTH, ALMOST_MTY, ALMOST_FULL);

    assign level[c*LVL_W +: LVL_W] = lvl;
    assign full[c]        = flg.full;
    assign empty[c]       = flg.empty;
    assign almost_full[c] = flg.almost_full;
    assign almost_mty[c]  = flg.almost_mty;
  end

  // Ops presented during reset must not touch pointers or storage.
  assign wr_acc  = !rst && wr_en && !full[wr_ch];
  assign rd_acc  = !rst && rd_en && !empty[rd_ch];
  assign wr_addr = {wr_ch, wr_ptr_q[wr_ch][LVL_W-2:0]};
  assign rd_addr = {rd_ch, rd_ptr_q[rd_ch][LVL_W-2:0]};

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_ovf_d = err_clr ? '0 : err_ovf_q;
    err_udf_d = err_clr ? '0 : err_udf_q;
    rd_vld_d  = rd_acc;
    if (wr_acc) begin
      wr_ptr_d[wr_ch] = wr_ptr_q[wr_ch] + LVL_W'(1);
    end
    if (rd_acc) begin
      rd_ptr_d[rd_ch] = rd_ptr_q[rd_ch] + LVL_W'(1);
    end
    // A new error on the clear cycle overrides the clear.
    if (wr_en && full[wr_ch]) begin
      err_ovf_d[wr_ch] = 1'b1;
    end
    if (rd_en && empty[rd_ch]) begin
      err_udf_d[rd_ch] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '{default: '0};
      rd_ptr_q  <= '{default: '0};
      err_ovf_q <= '0;
      err_udf_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  mc_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W),
    .ASYNC_RD   (FWFT)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_acc),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef MC_FIFO_FWFT_EN
  assign rd_vld = !empty[rd_ch];
`else
  assign rd_vld = rd_vld_q;
`endif

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;

endmodule

// File: tb/tb_mc_fifo.sv
// tb/tb_mc_fifo.sv - randomized self-checking bench for mc_fifo against per-channel queue model
module tb_mc_fifo;

  localparam int DW    = 128;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;
  localparam int LVL_W = 5;
  localparam int AMTY  = 3;
  localparam int AFULL = 3;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  wr_en, rd_en, err_clr;
  logic [CH_W-1:0]       wr_ch, rd_ch;
  logic [DW-1:0]         wr_data;
  logic [DW-1:0]         rd_data;
  logic                  rd_vld;
  logic [NCH-1:0]        full, empty, almost_full, almost_mty, err_ovf, err_udf;
  logic [NCH*LVL_W-1:0]  level;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0]  mq [NCH][$];
  logic [NCH-1:0] m_ovf, m_udf;
  logic [DW-1:0]  m_rd_data;
  logic           m_rd_vld;
  int             words_out;

  always #5 clk = ~clk;

  mc_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_ch       (rd_ch),
    .rd_data     (rd_data),
    .rd_vld      (rd_vld),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_mty  (almost_mty),
    .level       (level),
    .err_clr     (err_clr),
    .err_ovf     (err_ovf),
    .err_udf     (err_udf)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_all();
    for (int c = 0; c < NCH; c++) begin
      int n;
      n = mq[c].size();
      chk($sformatf("level[%0d]", c), level[c*LVL_W +: LVL_W], n);
      chk($sformatf("full[%0d]", c), full[c], n == DEPTH);
      chk($sformatf("empty[%0d]", c), empty[c], n == 0);
      chk($sformatf("almost_full[%0d]", c), almost_full[c], n >= DEPTH - AFULL);
      chk($sformatf("almost_mty[%0d]", c), almost_mty[c], n <= AMTY);
    end
    chk("rd_vld", rd_vld, m_rd_vld);
    chk("rd_data", rd_data, m_rd_data);
    chk("err_ovf", err_ovf, m_ovf);
    chk("err_udf", err_udf, m_udf);
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    err_clr = 1'b0;
    wr_ch   = '0;
    rd_ch   = '0;
    wr_data = '0;
  endtask

  task automatic step(input logic we, input int wc, input logic [DW-1:0] wd,
                      input logic re, input int rc, input logic ec);
    logic wa, ra;
    wr_en   = we;
    wr_ch   = wc[CH_W-1:0];
    wr_data = wd;
    rd_en   = re;
    rd_ch   = rc[CH_W-1:0];
    err_clr = ec;
    wa = we && (mq[wc].size() < DEPTH);
    ra = re && (mq[rc].size() > 0);
    @(posedge clk);
    #1;
    m_rd_vld = 1'b0;
    if (ra) begin
      m_rd_data = mq[rc].pop_front();
      m_rd_vld  = 1'b1;
      words_out++;
    end
    if (wa) mq[wc].push_back(wd);
    if (ec) begin
      m_ovf = '0;
      m_udf = '0;
    end
    if (we && !wa) m_ovf[wc] = 1'b1;
    if (re && !ra) m_udf[rc] = 1'b1;
    idle();
    check_all();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      rd_en   = 1'($urandom_range(0, 1));
      wr_ch   = CH_W'($urandom_range(0, NCH - 1));
      rd_ch   = CH_W'($urandom_range(0, NCH - 1));
      wr_data = rnd_word();
      err_clr = 1'b0;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    idle();
    for (int c = 0; c < NCH; c++) mq[c].delete();
    m_ovf     = '0;
    m_udf     = '0;
    m_rd_data = '0;
    m_rd_vld  = 1'b0;
    check_all();
  endtask

  task automatic rand_cycles(input int n, input int wr_pct, input int rd_pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset($urandom_range(1, 3));
      end else begin
        step($urandom_range(0, 99) < wr_pct, $urandom_range(0, NCH - 1), rnd_word(),
             $urandom_range(0, 99) < rd_pct, $urandom_range(0, NCH - 1),
             $urandom_range(0, 99) < 3);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    words_out = 0;
    idle();
    m_ovf     = '0;
    m_udf     = '0;
    m_rd_data = '0;
    m_rd_vld  = 1'b0;
    do_reset(2);

    // Reset in the middle of traffic
    rand_cycles(20, 70, 40);
    do_reset(3);
    chk("rst_empty", empty, 4'hF);
    chk("rst_level", level, 0);
    chk("rst_rd_vld", rd_vld, 0);

    // Fill ch2 to full, then overflow
    for (int i = 0; i < DEPTH; i++) step(1'b1, 2, rnd_word(), 1'b0, 0, 1'b0);
    chk("ch2_full", full[2], 1);
    chk("ch2_level", level[2*LVL_W +: LVL_W], 16);
    step(1'b1, 2, rnd_word(), 1'b0, 0, 1'b0);
    chk("ch2_ovf", err_ovf, 4'b0100);

    // Ordered reads with one-cycle latency on ch1
    step(1'b1, 1, 128'hA, 1'b0, 0, 1'b0);
    step(1'b1, 1, 128'hB, 1'b0, 0, 1'b0);
    step(1'b1, 1, 128'hC, 1'b0, 0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    chk("rd_A", rd_data, 128'hA);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    chk("rd_B", rd_data, 128'hB);
    step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    chk("rd_C", rd_data, 128'hC);
    chk("ch1_level0", level[1*LVL_W +: LVL_W], 0);

    // Same-channel collisions at full and at empty
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 0, rnd_word(), 1'b0, 0, 1'b0);
    step(1'b1, 0, rnd_word(), 1'b1, 0, 1'b0);
    chk("ch0_level15", level[0*LVL_W +: LVL_W], 15);
    chk("ch0_ovf", err_ovf[0], 1);
    step(1'b1, 3, rnd_word(), 1'b1, 3, 1'b0);
    chk("ch3_level1", level[3*LVL_W +: LVL_W], 1);
    chk("ch3_udf", err_udf[3], 1);

    // Sustained streaming through a pre-filled channel
    do_reset(1);
    for (int i = 0; i < 8; i++) step(1'b1, 3, rnd_word(), 1'b0, 0, 1'b0);
    words_out = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 3, rnd_word(), 1'b1, 3, 1'b0);
    chk("stream_words", words_out, 40);
    chk("stream_ovf", err_ovf, 0);
    chk("stream_udf", err_udf, 0);

    // Pointer wrap-around, then clear sticky errors
    do_reset(1);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1, rnd_word(), 1'b0, 0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 0, '0, 1'b1, 1, 1'b0);
    end
    step(1'b0, 0, '0, 1'b1, 2, 1'b0);
    chk("udf_set", err_udf, 4'b0100);
    step(1'b0, 0, '0, 1'b0, 0, 1'b1);
    chk("clr_ovf", err_ovf, 0);
    chk("clr_udf", err_udf, 0);

    // Error raised on the clear cycle wins
    step(1'b0, 0, '0, 1'b1, 0, 1'b1);
    chk("clr_vs_err", err_udf, 4'b0001);

    // Random traffic with alternating fill/drain bias
    for (int p = 0; p < 8; p++) begin
      if (p[0]) rand_cycles(250, 30, 80);
      else      rand_cycles(250, 85, 30);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
